// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one request in flight, fixed wait latency,
// RV32I byte-lane stores and sign/zero-extended loads, error flag on bad accesses.
module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q;
    logic [DM_ADDRESS-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [2:0]              f3_q;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    accept, enter_resp;
    logic [DATA_W-1:0]       mem [WORDS];
    logic [DATA_W-1:0]       word, shifted, lane_w;
    logic [3:0]              be;
    logic [1:0]              bo;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // WAIT always spends LATENCY+1 cycles so the response lands LATENCY+1 edges after accept.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = WAIT;
                cnt_d   = 4'(LATENCY);
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bo      = addr_q[1:0];
    assign word    = mem[addr_q[DM_ADDRESS-1:2]];
    assign shifted = word >> {bo, 3'b000};

    // Error paths leave be at zero, which is what suppresses the array write.
    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        be      = 4'b0000;
        lane_w  = '0;
        case (f3_q)
            3'b000: if (wr_q) begin
                be     = 4'b0001 << bo;
                lane_w = {4{wdata_q[7:0]}};
            end else begin
                rdata_d = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            end
            3'b001: if (bo[0]) err_d = 1'b1;
                else if (wr_q) begin
                    be     = 4'b0011 << bo;
                    lane_w = {2{wdata_q[15:0]}};
                end else begin
                    rdata_d = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
                end
            3'b010: if (bo != 2'b00) err_d = 1'b1;
                else if (wr_q) begin
                    be     = 4'b1111;
                    lane_w = wdata_q;
                end else begin
                    rdata_d = word;
                end
            3'b100: if (wr_q) err_d = 1'b1;
                else rdata_d = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b101: if (wr_q || bo[0]) err_d = 1'b1;
                else rdata_d = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Storage is not reset; enter_resp is gated by the reset state so aborted stores never land.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= lane_w[8*i +: 8];
        end
    end
endmodule
